// File: rtl/jtag_uart_cmd_decoder.sv
// Host command decoder: polls the JTAG-UART data register, strips the escape layer,
// decodes LOAD/SELECT commands, streams pixel bytes and returns ACK/NAK replies.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a command byte
// S_ERROR   | last command failed, oERR_CODE holds the cause
// S_SELECT  | range-check the requested frame index against NUM_IMAGES
// S_TRIGGER | one-cycle SDRAM write trigger before pixel streaming
// S_LOAD    | streaming pixel bytes until the frame-set byte count is hit
// S_DONE    | waiting for the completion ACK to leave the UART write path
// S_WAIT_ACK| waiting for the host to acknowledge the completed load
module jtag_uart_cmd_decoder #(
  parameter int          FRAME_BYTES_LOG2 = 20,
  parameter logic [7:0]  ESC_BYTE         = 8'hFE,
  parameter logic [7:0]  ACK_BYTE         = 8'hA5,
  parameter logic [7:0]  NAK_BYTE         = 8'hE0
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oJTAG_SLAVE_ADDR,
  output logic        oJTAG_SLAVE_RDREQ,
  input  logic [31:0] iJTAG_SLAVE_RDDATA,
  output logic        oJTAG_SLAVE_WRREQ,
  output logic [31:0] oJTAG_SLAVE_WRDATA,
  input  logic        iJTAG_SLAVE_WAIT,
  output logic [7:0]  oPIX_DATA,
  output logic        oPIX_VALID,
  input  logic        iPIX_READY,
  output logic [6:0]  oNUM_IMAGES,
  output logic        oTRIGGER_WRITE_SDRAM,
  output logic [5:0]  oFRAME_SEL,
  output logic        oFRAME_SEL_VALID,
  output logic        oBUSY,
  output logic        oERROR,
  output logic [1:0]  oERR_CODE
);

  localparam int CW = FRAME_BYTES_LOG2 + 7;

  typedef enum logic [2:0] {
    S_IDLE, S_ERROR, S_SELECT, S_TRIGGER, S_LOAD, S_DONE, S_WAIT_ACK
  } state_t;

  state_t          state_q, state_d;
  logic            esc_q, esc_d;
  logic [6:0]      num_q, num_d;
  logic [5:0]      fsel_q, fsel_d;
  logic            fsv_q, fsv_d;
  logic [5:0]      sel_idx_q, sel_idx_d;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pix_valid_q, pix_valid_d;
  logic [7:0]      pix_data_q, pix_data_d;

  logic            rx_valid_q;
  logic [7:0]      rx_byte_q;
  logic            rd_q, wr_q;
  logic [7:0]      wr_byte_q;
  logic            tx_pend_q;
  logic [7:0]      tx_byte_q;

  logic            tx_req, tx_nak;
  logic            ev_data, ev_abort, ev_hack, ev_badesc;
  logic            launch, rd_allow;
  logic [CW-1:0]   term, cnt_inc;
  logic            unused_rddata;

  assign unused_rddata = &{1'b0, iJTAG_SLAVE_RDDATA[31:16], iJTAG_SLAVE_RDDATA[14:8]};

  // A fully loaded 64-frame set lands exactly on the counter MSB
  assign term    = {num_q, {FRAME_BYTES_LOG2{1'b0}}};
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    esc_d     = esc_q;
    ev_data   = 1'b0;
    ev_abort  = 1'b0;
    ev_hack   = 1'b0;
    ev_badesc = 1'b0;
    if (rx_valid_q) begin
      if (esc_q) begin
        esc_d = 1'b0;
        case (rx_byte_q)
          8'h00:    ev_abort  = 1'b1;
          8'h01:    ev_hack   = 1'b1;
          ESC_BYTE: ev_data   = 1'b1;
          default:  ev_badesc = 1'b1;
        endcase
      end else if (rx_byte_q == ESC_BYTE) begin
        esc_d = 1'b1;
      end else begin
        ev_data = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    fsel_d      = fsel_q;
    fsv_d       = 1'b0;
    sel_idx_d   = sel_idx_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    tx_req      = 1'b0;
    tx_nak      = 1'b0;

    if (pix_valid_q && iPIX_READY) begin
      pix_valid_d = 1'b0;
      cnt_d       = cnt_inc;
      if (cnt_inc == term) begin
        tx_req  = 1'b1;
        state_d = S_DONE;
      end
    end

    case (state_q)
      S_SELECT: begin
        if ({1'b0, sel_idx_q} < num_q) begin
          fsel_d  = sel_idx_q;
          fsv_d   = 1'b1;
          err_d   = 2'd0;
          tx_req  = 1'b1;
          state_d = S_IDLE;
        end else begin
          err_d   = 2'd3;
          tx_req  = 1'b1;
          tx_nak  = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_TRIGGER: state_d = S_LOAD;
      S_DONE: begin
        if (!tx_pend_q && !wr_q) state_d = S_WAIT_ACK;
      end
      default: ;
    endcase

    if (ev_abort) begin
      pix_valid_d = 1'b0;
      cnt_d       = '0;
      err_d       = 2'd0;
      tx_req      = 1'b1;
      tx_nak      = 1'b0;
      state_d     = S_IDLE;
    end else if (ev_badesc) begin
      err_d   = 2'd2;
      tx_req  = 1'b1;
      tx_nak  = 1'b1;
      state_d = S_ERROR;
    end else if (ev_hack) begin
      if (state_q == S_WAIT_ACK) begin
        state_d = S_IDLE;
      end else begin
        err_d   = 2'd3;
        tx_req  = 1'b1;
        tx_nak  = 1'b1;
        state_d = S_ERROR;
      end
    end else if (ev_data) begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (rx_byte_q[7:6] == 2'b10) begin
            num_d   = {1'b0, rx_byte_q[5:0]} + 7'd1;
            cnt_d   = '0;
            err_d   = 2'd0;
            state_d = S_TRIGGER;
          end else if (rx_byte_q[7:6] == 2'b11) begin
            sel_idx_d = rx_byte_q[5:0];
            state_d   = S_SELECT;
          end else begin
            err_d   = 2'd1;
            tx_req  = 1'b1;
            tx_nak  = 1'b1;
            state_d = S_ERROR;
          end
        end
        S_LOAD: begin
          pix_valid_d = 1'b1;
          pix_data_d  = rx_byte_q;
        end
        S_WAIT_ACK: begin
          err_d   = 2'd3;
          tx_req  = 1'b1;
          tx_nak  = 1'b1;
          state_d = S_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      esc_q       <= 1'b0;
      num_q       <= '0;
      fsel_q      <= '0;
      fsv_q       <= 1'b0;
      sel_idx_q   <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      esc_q       <= esc_d;
      num_q       <= num_d;
      fsel_q      <= fsel_d;
      fsv_q       <= fsv_d;
      sel_idx_q   <= sel_idx_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  // Bus owner: one Avalon access at a time, pending reply beats polling
  assign launch   = !rd_q && !wr_q && tx_pend_q;
  assign rd_allow = !tx_pend_q && !tx_req && !pix_valid_q && !rx_valid_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wr_byte_q  <= '0;
      tx_pend_q  <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rd_q) begin
        if (!iJTAG_SLAVE_WAIT) begin
          if (iJTAG_SLAVE_RDDATA[15]) begin
            rx_valid_q <= 1'b1;
            rx_byte_q  <= iJTAG_SLAVE_RDDATA[7:0];
            rd_q       <= 1'b0;
          end else begin
            rd_q <= rd_allow;
          end
        end
      end else if (wr_q) begin
        if (!iJTAG_SLAVE_WAIT) wr_q <= 1'b0;
      end else if (tx_pend_q) begin
        wr_q      <= 1'b1;
        wr_byte_q <= tx_byte_q;
      end else if (rd_allow) begin
        rd_q <= 1'b1;
      end

      // Single-entry reply slot: a queued NAK is never overwritten by an ACK
      if (tx_req) begin
        tx_pend_q <= 1'b1;
        if (!(tx_pend_q && !launch && tx_byte_q == NAK_BYTE))
          tx_byte_q <= tx_nak ? NAK_BYTE : ACK_BYTE;
      end else if (launch) begin
        tx_pend_q <= 1'b0;
      end
    end
  end

  assign oJTAG_SLAVE_ADDR     = 1'b0;
  assign oJTAG_SLAVE_RDREQ    = rd_q;
  assign oJTAG_SLAVE_WRREQ    = wr_q;
  assign oJTAG_SLAVE_WRDATA   = {24'd0, wr_byte_q};
  assign oPIX_DATA            = pix_data_q;
  assign oPIX_VALID           = pix_valid_q;
  assign oNUM_IMAGES          = num_q;
  assign oTRIGGER_WRITE_SDRAM = (state_q == S_TRIGGER);
  assign oFRAME_SEL           = fsel_q;
  assign oFRAME_SEL_VALID     = fsv_q;
  assign oBUSY                = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign oERROR               = (state_q == S_ERROR);
  assign oERR_CODE            = err_q;

endmodule

// File: tb/tb_jtag_uart_cmd_decoder.sv
// Directed bench for jtag_uart_cmd_decoder: host UART byte source, reply logger
// and pixel sink models, with hand-computed expectations at each step.
module tb_jtag_uart_cmd_decoder;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        oJTAG_SLAVE_ADDR;
  logic        oJTAG_SLAVE_RDREQ;
  logic [31:0] iJTAG_SLAVE_RDDATA;
  logic        oJTAG_SLAVE_WRREQ;
  logic [31:0] oJTAG_SLAVE_WRDATA;
  logic        iJTAG_SLAVE_WAIT;
  logic [7:0]  oPIX_DATA;
  logic        oPIX_VALID;
  logic        iPIX_READY;
  logic [6:0]  oNUM_IMAGES;
  logic        oTRIGGER_WRITE_SDRAM;
  logic [5:0]  oFRAME_SEL;
  logic        oFRAME_SEL_VALID;
  logic        oBUSY;
  logic        oERROR;
  logic [1:0]  oERR_CODE;

  jtag_uart_cmd_decoder #(.FRAME_BYTES_LOG2(4)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oJTAG_SLAVE_ADDR(oJTAG_SLAVE_ADDR), .oJTAG_SLAVE_RDREQ(oJTAG_SLAVE_RDREQ),
    .iJTAG_SLAVE_RDDATA(iJTAG_SLAVE_RDDATA), .oJTAG_SLAVE_WRREQ(oJTAG_SLAVE_WRREQ),
    .oJTAG_SLAVE_WRDATA(oJTAG_SLAVE_WRDATA), .iJTAG_SLAVE_WAIT(iJTAG_SLAVE_WAIT),
    .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID), .iPIX_READY(iPIX_READY),
    .oNUM_IMAGES(oNUM_IMAGES), .oTRIGGER_WRITE_SDRAM(oTRIGGER_WRITE_SDRAM),
    .oFRAME_SEL(oFRAME_SEL), .oFRAME_SEL_VALID(oFRAME_SEL_VALID),
    .oBUSY(oBUSY), .oERROR(oERROR), .oERR_CODE(oERR_CODE)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] host_mem [0:255];
  int         host_wr = 0;
  int         host_rd = 0;
  logic       inv_mode = 1'b0;
  logic       inv_phase = 1'b0;
  logic       rsp_valid;

  logic [7:0] tx_log  [0:31];
  int         tx_cnt = 0;
  logic [7:0] pix_log [0:127];
  int         pix_cnt = 0;
  int         trig_cnt = 0;
  int         fsv_cnt = 0;

  always_comb begin
    rsp_valid = (host_rd < host_wr) && !(inv_mode && inv_phase);
    iJTAG_SLAVE_RDDATA = rsp_valid ? {16'h0000, 8'h80, host_mem[host_rd[7:0]]} : 32'h0000_0033;
  end

  always @(posedge iCLK) begin
    if (oJTAG_SLAVE_RDREQ && !iJTAG_SLAVE_WAIT) begin
      if (rsp_valid) host_rd <= host_rd + 1;
      if (inv_mode) inv_phase <= !inv_phase;
    end
    if (oJTAG_SLAVE_WRREQ && !iJTAG_SLAVE_WAIT) begin
      tx_log[tx_cnt[4:0]] <= oJTAG_SLAVE_WRDATA[7:0];
      tx_cnt <= tx_cnt + 1;
    end
    if (oPIX_VALID && iPIX_READY) begin
      pix_log[pix_cnt[6:0]] <= oPIX_DATA;
      pix_cnt <= pix_cnt + 1;
    end
    if (oTRIGGER_WRITE_SDRAM) trig_cnt <= trig_cnt + 1;
    if (oFRAME_SEL_VALID) fsv_cnt <= fsv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    host_mem[host_wr[7:0]] = b;
    host_wr++;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (host_rd != host_wr && k < budget) begin @(negedge iCLK); k++; end
    chk("host_drain", 32'(host_rd), 32'(host_wr));
    repeat (12) @(negedge iCLK);
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_cnt < n && k < budget) begin @(negedge iCLK); k++; end
    repeat (2) @(negedge iCLK);
    chk("tx_count", 32'(tx_cnt), 32'(n));
  endtask

  int bad, rd_bad, hr, tc, k;

  initial begin
    iRST = 1'b1;
    iJTAG_SLAVE_WAIT = 1'b0;
    iPIX_READY = 1'b1;
    #1;
    chk("rst_rdreq", 32'(oJTAG_SLAVE_RDREQ), 0);
    chk("rst_wrreq", 32'(oJTAG_SLAVE_WRREQ), 0);
    chk("rst_wrdata", oJTAG_SLAVE_WRDATA, 0);
    chk("rst_pix_valid", 32'(oPIX_VALID), 0);
    chk("rst_num", 32'(oNUM_IMAGES), 0);
    chk("rst_err", 32'(oERR_CODE), 0);
    chk("rst_busy", 32'(oBUSY), 0);
    chk("rst_addr", 32'(oJTAG_SLAVE_ADDR), 0);
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    repeat (4) @(negedge iCLK);

    // 1: two-frame load of 32 bytes, then host ack
    push(8'h81);
    for (int i = 0; i < 32; i++) push(8'(i));
    wait_tx(1, 1000);
    chk("t1_ack", 32'(tx_log[0]), 32'hA5);
    chk("t1_trig_width", 32'(trig_cnt), 1);
    chk("t1_num", 32'(oNUM_IMAGES), 2);
    chk("t1_pix_cnt", 32'(pix_cnt), 32);
    for (int i = 0; i < 32; i++) chk("t1_pix_data", 32'(pix_log[i]), 32'(i));
    chk("t1_busy_wait_ack", 32'(oBUSY), 1);
    push(8'hFE); push(8'h01);
    wait_drain(200);
    chk("t1_idle_busy", 32'(oBUSY), 0);
    chk("t1_no_extra_tx", 32'(tx_cnt), 1);

    // 2: escaped literal pixel, then bad escape
    push(8'h80); push(8'hFE); push(8'hFE);
    wait_drain(200);
    chk("t2_pix_cnt", 32'(pix_cnt), 33);
    chk("t2_lit_fe", 32'(pix_log[32]), 32'hFE);
    chk("t2_busy", 32'(oBUSY), 1);
    push(8'hFE); push(8'h02);
    wait_tx(2, 300);
    chk("t2_nak", 32'(tx_log[1]), 32'hE0);
    chk("t2_err_code", 32'(oERR_CODE), 2);
    chk("t2_error", 32'(oERROR), 1);

    // 3: sink stall mid-load
    push(8'h80);
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    wait_drain(300);
    chk("t3_err_cleared", 32'(oERR_CODE), 0);
    iPIX_READY = 1'b0;
    for (int i = 4; i < 16; i++) push(8'(8'h40 + i));
    k = 0;
    while (!oPIX_VALID && k < 50) begin @(negedge iCLK); k++; end
    chk("t3_held_data", 32'(oPIX_DATA), 32'h44);
    hr = host_rd; bad = 0; rd_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      if (!oPIX_VALID || oPIX_DATA != 8'h44) bad++;
      if (oJTAG_SLAVE_RDREQ) rd_bad++;
    end
    chk("t3_valid_stable", 32'(bad), 0);
    chk("t3_no_rdreq", 32'(rd_bad), 0);
    chk("t3_no_reads", 32'(host_rd), 32'(hr));
    iPIX_READY = 1'b1;
    wait_tx(3, 1000);
    chk("t3_ack", 32'(tx_log[2]), 32'hA5);
    chk("t3_pix_cnt", 32'(pix_cnt), 49);
    for (int i = 0; i < 16; i++) chk("t3_pix_data", 32'(pix_log[33 + i]), 32'(8'h40 + i));
    push(8'hFE); push(8'h01);
    wait_drain(200);
    chk("t3_idle", 32'(oBUSY), 0);

    // 4: frame select in and out of range
    push(8'h81);
    wait_drain(200);
    chk("t4_num", 32'(oNUM_IMAGES), 2);
    push(8'hFE); push(8'h00);
    wait_tx(4, 300);
    chk("t4_abort_ack", 32'(tx_log[3]), 32'hA5);
    chk("t4_abort_idle", 32'(oBUSY), 0);
    push(8'hC1);
    wait_tx(5, 300);
    chk("t4_sel_ack", 32'(tx_log[4]), 32'hA5);
    chk("t4_frame_sel", 32'(oFRAME_SEL), 1);
    chk("t4_fsv_pulse", 32'(fsv_cnt), 1);
    push(8'hC5);
    wait_tx(6, 300);
    chk("t4_sel_nak", 32'(tx_log[5]), 32'hE0);
    chk("t4_err_code", 32'(oERR_CODE), 3);
    chk("t4_error", 32'(oERROR), 1);
    chk("t4_frame_sel_kept", 32'(oFRAME_SEL), 1);
    chk("t4_fsv_no_pulse", 32'(fsv_cnt), 1);

    // 5: waitrequest on read and write, then invalid reads interleaved
    @(negedge iCLK);
    iJTAG_SLAVE_WAIT = 1'b1;
    push(8'hC0);
    hr = host_rd; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (!oJTAG_SLAVE_RDREQ) bad++;
    end
    chk("t5_rdreq_held", 32'(bad), 0);
    chk("t5_rd_no_pop", 32'(host_rd), 32'(hr));
    iJTAG_SLAVE_WAIT = 1'b0;
    k = 0;
    while (!oJTAG_SLAVE_WRREQ && k < 100) begin @(negedge iCLK); k++; end
    iJTAG_SLAVE_WAIT = 1'b1;
    chk("t5_wrreq_seen", 32'(oJTAG_SLAVE_WRREQ), 1);
    tc = tx_cnt; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      if (!oJTAG_SLAVE_WRREQ || oJTAG_SLAVE_WRDATA != 32'hA5 || oJTAG_SLAVE_RDREQ) bad++;
    end
    chk("t5_wrreq_held", 32'(bad), 0);
    chk("t5_wr_no_log", 32'(tx_cnt), 32'(tc));
    iJTAG_SLAVE_WAIT = 1'b0;
    wait_tx(7, 300);
    chk("t5_sel_ack", 32'(tx_log[6]), 32'hA5);
    chk("t5_frame_sel", 32'(oFRAME_SEL), 0);
    chk("t5_err_cleared", 32'(oERR_CODE), 0);
    chk("t5_fsv_pulse", 32'(fsv_cnt), 2);
    inv_mode = 1'b1;
    push(8'h80);
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    wait_tx(8, 2000);
    chk("t5_load_ack", 32'(tx_log[7]), 32'hA5);
    chk("t5_pix_cnt", 32'(pix_cnt), 65);
    for (int i = 0; i < 16; i++) chk("t5_pix_data", 32'(pix_log[49 + i]), 32'(8'h60 + i));
    push(8'hFE); push(8'h01);
    wait_drain(300);
    chk("t5_idle", 32'(oBUSY), 0);
    inv_mode = 1'b0;

    // 6: abort mid-load, then async reset with a pixel held
    push(8'h80); push(8'h11); push(8'h22);
    wait_drain(300);
    chk("t6_pix_cnt", 32'(pix_cnt), 67);
    push(8'hFE); push(8'h00);
    wait_tx(9, 300);
    chk("t6_abort_ack", 32'(tx_log[8]), 32'hA5);
    chk("t6_abort_pv", 32'(oPIX_VALID), 0);
    chk("t6_abort_idle", 32'(oBUSY), 0);
    iPIX_READY = 1'b0;
    push(8'h80); push(8'h77);
    wait_drain(300);
    chk("t6_held_valid", 32'(oPIX_VALID), 1);
    chk("t6_held_data", 32'(oPIX_DATA), 32'h77);
    @(negedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("t6_rst_pv", 32'(oPIX_VALID), 0);
    chk("t6_rst_pdata", 32'(oPIX_DATA), 0);
    chk("t6_rst_num", 32'(oNUM_IMAGES), 0);
    chk("t6_rst_busy", 32'(oBUSY), 0);
    chk("t6_rst_fsel", 32'(oFRAME_SEL), 0);
    chk("t6_rst_wrdata", oJTAG_SLAVE_WRDATA, 0);
    chk("t6_rst_rdreq", 32'(oJTAG_SLAVE_RDREQ), 0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    iPIX_READY = 1'b1;
    repeat (40) @(negedge iCLK);
    chk("t6_no_reply", 32'(tx_cnt), 9);
    chk("t6_pix_dropped", 32'(pix_cnt), 67);
    chk("t6_idle", 32'(oBUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_uart_cmd_decoder.md
Name: jtag_uart_cmd_decoder

Overview:
- Parametrised next-generation host-command decoder between the JTAG-UART Avalon slave and the SDRAM image-write path.
- Polls the UART data register, strips the 0xFE escape, and decodes LOAD and SELECT commands.
- Streams pixel bytes out over a valid/ready handshake with backpressure.
- Returns ACK/NAK reply bytes to the host through the UART write path.

Parameters:
FRAME_BYTES_LOG2, 20, log2 of bytes per frame (sims use 4)
ESC_BYTE, 8'hFE, escape character
ACK_BYTE, 8'hA5, reply on success
NAK_BYTE, 8'hE0, reply on error

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-high
oJTAG_SLAVE_ADDR  out  1  constant 0 (data register)
oJTAG_SLAVE_RDREQ  out  1  Avalon read
iJTAG_SLAVE_RDDATA  in  32  [7:0] byte, [15] RVALID
oJTAG_SLAVE_WRREQ  out  1  Avalon write
oJTAG_SLAVE_WRDATA  out  32  {24'd0, reply byte}
iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest
oPIX_DATA  out  8  pixel byte
oPIX_VALID  out  1  pixel valid
iPIX_READY  in  1  sink accepts when VALID&&READY
oNUM_IMAGES  out  7  frames of last LOAD (1..64)
oTRIGGER_WRITE_SDRAM  out  1  1-cycle pulse at LOAD start
oFRAME_SEL  out  6  selected frame index
oFRAME_SEL_VALID  out  1  1-cycle pulse on new selection
oBUSY  out  1  state not IDLE/ERROR
oERROR  out  1  state==ERROR
oERR_CODE  out  2  1=bad opcode, 2=bad escape, 3=bad ack/select range; sticky until next valid command

Behaviour:
- Reset values: RDREQ=0, WRREQ=0, WRDATA=0, PIX_VALID=0, PIX_DATA=0, NUM_IMAGES=0, FRAME_SEL=0, all pulses 0, ERR_CODE=0, state IDLE, TX/escape flags clear. Reset mid-transfer abandons everything with no reply sent.
- Avalon access:
  - One access at a time. A pending TX reply has priority over reads.
  - RDREQ asserts only when no TX is pending and the pixel holding register is empty.
  - RDREQ/WRREQ are held until WAIT=0. The read completes in that cycle and the byte is valid only if RDDATA[15]=1; otherwise it is discarded and RDREQ re-issues next cycle.
  - A decoded byte reaches the FSM 1 cycle after the completing read.
- Escape layer:
  - An ESC byte sets esc_pending and is consumed.
  - The byte following ESC is decoded as: 00=ABORT, 01=HOST_ACK, FE=literal data 0xFE, any other value=bad escape (code 2).
- FSM states: IDLE, ERROR, SELECT, TRIGGER, LOAD, DONE, WAIT_ACK.
- IDLE/ERROR, normal (non-escaped) byte:
  - 10nn_nnnn: NUM_IMAGES=n+1; clear byte counter; go to TRIGGER, which pulses TRIGGER_WRITE_SDRAM for 1 cycle, then go to LOAD.
  - 11ff_ffff: if f<NUM_IMAGES, FRAME_SEL=f, pulse FRAME_SEL_VALID, queue ACK, go to IDLE; else code 3, queue NAK, go to ERROR.
  - Any other byte: code 1, queue NAK, go to ERROR.
  - Any valid command clears ERR_CODE.
- LOAD:
  - Every non-escape byte (and escaped FE) loads the pixel register: PIX_VALID=1, held until READY.
  - The byte counter (FRAME_BYTES_LOG2+7 bits) increments on each accept.
  - When the accept makes counter == NUM_IMAGES<<FRAME_BYTES_LOG2, queue ACK and go to DONE.
- DONE: wait until the ACK has been written, then go to WAIT_ACK.
- WAIT_ACK: HOST_ACK goes to IDLE. Any other byte gives code 3, queues NAK, goes to ERROR.
- ABORT in any state: clear PIX_VALID, drop the counter, queue ACK, go to IDLE.
- HOST_ACK outside WAIT_ACK: code 3, queue NAK, go to ERROR.
- Bad escape in any state: code 2, queue NAK, go to ERROR.
- TX queue depth is 1. A new reply while one is pending overwrites it, and NAK wins.
- Simultaneous PIX accept and new UART byte cannot occur: reads are blocked while the holding register is full.
- 64-frame load with FRAME_BYTES_LOG2=20 gives a terminal count of 2^26, which must fit the 27-bit counter.

Test Plan:
1. FRAME_BYTES_LOG2=4, send 0x81 then 32 bytes 0..31, READY=1: TRIGGER pulse 1 cycle, NUM_IMAGES=2, 32 pixels in order, WRDATA=0xA5 once. Then send FE 01: returns to IDLE, BUSY=0.
2. In LOAD, send FE FE: one pixel 0xFE emitted, counter +1. Send FE 02: ERR_CODE=2, ERROR, NAK 0xE0 written.
3. READY=0 for 50 cycles mid-load: PIX_VALID held with stable data, RDREQ=0 throughout, no bytes lost after READY=1.
4. NUM_IMAGES=2, send 0xC1: FRAME_SEL=1, one-cycle FRAME_SEL_VALID, ACK written. Send 0xC5: ERR_CODE=3, NAK written, FRAME_SEL stays 1.
5. WAIT held high 20 cycles during a read and a write, RDDATA[15]=0 responses interleaved: no duplicate or phantom bytes, RDREQ/WRREQ stable while waiting.
6. Mid-load FE 00: PIX_VALID drops next cycle, ACK written, IDLE. Async iRST mid-load: all outputs return to reset values immediately with no reply.
